// File: rtl/imem_prefetch_buf_if.sv
// Bundle of the instruction-memory port, the IF/ID issue handshake and the EX redirect.
// master: the prefetch buffer. slave: the memory/core environment around it.
interface imem_prefetch_buf_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack_n;
  logic [31:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc4;
  logic        misalign;

  modport master (
    input  redirect, redirect_pc, mem_ack_n, mem_rdata, ir_ready,
    output mem_addr, mem_req, ir_valid, ir, ir_pc, ir_pc4, misalign
  );

  modport slave (
    output redirect, redirect_pc, mem_ack_n, mem_rdata, ir_ready,
    input  mem_addr, mem_req, ir_valid, ir, ir_pc, ir_pc4, misalign
  );
endinterface

// File: rtl/imem_prefetch_buf.sv
// Sequential instruction prefetch FIFO that hides memory wait states from IF/ID.
// A redirect flushes every buffered word and restarts fetch at the new aligned PC.
module imem_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  imem_prefetch_buf_if.master bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t             store [DEPTH];
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               misalign_q;

  logic   has_room;
  logic   push;
  logic   pop;
  entry_t head;

  // Request and issue decode; request never looks at ack or ready.
  always_comb begin
    has_room     = (count < CNT_W'(DEPTH));
    head         = store[rd_ptr];
    bus.mem_addr = fetch_pc;
    bus.mem_req  = rst_n && !bus.redirect && has_room;
    bus.ir_valid = (count != '0);
    bus.misalign = misalign_q;
    bus.ir       = '0;
    bus.ir_pc    = '0;
    bus.ir_pc4   = '0;
    if (bus.ir_valid) begin
      bus.ir     = head.word;
      bus.ir_pc  = head.pc;
      bus.ir_pc4 = head.pc + 32'd4;
    end
    push = bus.mem_req && !bus.mem_ack_n;
    pop  = bus.ir_valid && bus.ir_ready;
  end

  // Redirect outranks both push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misalign_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (bus.redirect) begin
      fetch_pc   <= {bus.redirect_pc[31:2], 2'b00};
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      misalign_q <= misalign_q | (bus.redirect_pc[1:0] != 2'b00);
    end else begin
      if (push) begin
        store[wr_ptr] <= '{pc: fetch_pc, word: bus.mem_rdata};
        wr_ptr        <= wr_ptr + PTR_W'(1);
        fetch_pc      <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_prefetch_buf.sv
// Directed bench for imem_prefetch_buf: streaming, backpressure, wait states, redirect, wrap, reset.
// Memory model returns addr ^ 32'hA5A5_A5A5 for every fetched address.
module tb_imem_prefetch_buf;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  imem_prefetch_buf_if bus ();

  imem_prefetch_buf #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_A5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.mem_ack_n = 1'b1;
    bus.ir_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0h exp 0", bus.mem_req); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid got %0h exp 0", bus.ir_valid); end
    n_checks++; if (bus.ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir got %08h exp 0", bus.ir); end
    n_checks++; if (bus.ir_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ir_pc got %08h exp 0", bus.ir_pc); end
    n_checks++; if (bus.ir_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_ir_pc4 got %08h exp 0", bus.ir_pc4); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %08h exp 0", bus.mem_addr); end
    n_checks++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %0h exp 0", bus.misalign); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    do_reset();
    bus.mem_ack_n = 1'b0;
    bus.ir_ready = 1'b1;
    #1;
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL stream_first_req got %0h exp 1", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_first_addr got %08h exp 0", bus.mem_addr); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid got %0h exp 0", bus.ir_valid); end
    for (int k = 0; k < 6; k++) begin
      tick();
      pc = 32'(k) * 32'd4;
      n_checks++; if (bus.ir_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0h exp 1", k, bus.ir_valid); end
      n_checks++; if (bus.ir_pc !== pc) begin n_fail++; $display("FAIL stream_pc[%0d] got %08h exp %08h", k, bus.ir_pc, pc); end
      n_checks++; if (bus.ir !== (pc ^ 32'hA5A5_A5A5)) begin n_fail++; $display("FAIL stream_ir[%0d] got %08h exp %08h", k, bus.ir, pc ^ 32'hA5A5_A5A5); end
      n_checks++; if (bus.ir_pc4 !== pc + 32'd4) begin n_fail++; $display("FAIL stream_pc4[%0d] got %08h exp %08h", k, bus.ir_pc4, pc + 32'd4); end
    end
  endtask

  task automatic test_fill_backpressure();
    do_reset();
    bus.mem_ack_n = 1'b0;
    bus.ir_ready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL fill_req[%0d] got %0h exp 1", k, bus.mem_req); end
      n_checks++; if (bus.mem_addr !== 32'(k) * 32'd4) begin n_fail++; $display("FAIL fill_addr[%0d] got %08h exp %08h", k, bus.mem_addr, 32'(k) * 32'd4); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req[%0d] got %0h exp 0", k, bus.mem_req); end
      n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL full_addr[%0d] got %08h exp 10", k, bus.mem_addr); end
      n_checks++; if (bus.ir_pc !== 32'h0) begin n_fail++; $display("FAIL full_head[%0d] got %08h exp 0", k, bus.ir_pc); end
      tick();
    end
    bus.ir_ready = 1'b1;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL pop_full_req got %0h exp 0", bus.mem_req); end
    tick();
    n_checks++; if (bus.ir_pc !== 32'h4) begin n_fail++; $display("FAIL after_pop_head got %08h exp 4", bus.ir_pc); end
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL after_pop_req got %0h exp 1", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL after_pop_addr got %08h exp 10", bus.mem_addr); end
    tick();
    n_checks++; if (bus.ir_pc !== 32'h8) begin n_fail++; $display("FAIL after_pop_head2 got %08h exp 8", bus.ir_pc); end
  endtask

  task automatic test_wait_states();
    logic exp_valid;
    do_reset();
    bus.ir_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < 4; w++) begin
        bus.mem_ack_n = (w < 3);
        #1;
        exp_valid = (f > 0) && (w == 0);
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req[%0d.%0d] got %0h exp 1", f, w, bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 32'(f) * 32'd4) begin n_fail++; $display("FAIL wait_addr[%0d.%0d] got %08h exp %08h", f, w, bus.mem_addr, 32'(f) * 32'd4); end
        n_checks++; if (bus.ir_valid !== exp_valid) begin n_fail++; $display("FAIL wait_valid[%0d.%0d] got %0h exp %0h", f, w, bus.ir_valid, exp_valid); end
        if (exp_valid) begin
          n_checks++; if (bus.ir_pc !== 32'(f - 1) * 32'd4) begin n_fail++; $display("FAIL wait_pc[%0d] got %08h exp %08h", f, bus.ir_pc, 32'(f - 1) * 32'd4); end
        end
        tick();
      end
    end
    bus.mem_ack_n = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    bus.mem_ack_n = 1'b0;
    bus.ir_ready = 1'b0;
    #1;
    tick(); tick(); tick();
    n_checks++; if (bus.mem_addr !== 32'hC) begin n_fail++; $display("FAIL redir_pre_addr got %08h exp c", bus.mem_addr); end
    bus.ir_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_same got %0h exp 0", bus.mem_req); end
    tick();
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %0h exp 0", bus.ir_valid); end
    n_checks++; if (bus.ir_pc !== 32'h0) begin n_fail++; $display("FAIL redir_pc_zero got %08h exp 0", bus.ir_pc); end
    n_checks++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got %08h exp 100", bus.mem_addr); end
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL redir_req got %0h exp 1", bus.mem_req); end
    tick();
    n_checks++; if (bus.ir_pc !== 32'h100) begin n_fail++; $display("FAIL redir_first_pc got %08h exp 100", bus.ir_pc); end
    n_checks++; if (bus.ir !== 32'hA5A5_A4A5) begin n_fail++; $display("FAIL redir_first_ir got %08h exp a5a5a4a5", bus.ir); end
    tick();
    n_checks++; if (bus.ir_pc !== 32'h104) begin n_fail++; $display("FAIL redir_second_pc got %08h exp 104", bus.ir_pc); end
    n_checks++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL redir_misalign got %0h exp 0", bus.misalign); end
  endtask

  task automatic test_misalign_wrap();
    bus.ir_ready = 1'b1;
    bus.mem_ack_n = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    tick();
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.misalign !== 1'b1) begin n_fail++; $display("FAIL mis_set got %0h exp 1", bus.misalign); end
    n_checks++; if (bus.mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mis_addr got %08h exp fffffffc", bus.mem_addr); end
    tick();
    n_checks++; if (bus.ir_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %08h exp fffffffc", bus.ir_pc); end
    n_checks++; if (bus.ir_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %08h exp 0", bus.ir_pc4); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %08h exp 0", bus.mem_addr); end
    tick();
    n_checks++; if (bus.ir_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc got %08h exp 0", bus.ir_pc); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.misalign !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got %0h exp 1", bus.misalign); end
  endtask

  task automatic test_reset_midstream();
    bus.ir_ready = 1'b0;
    bus.mem_ack_n = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    #1;
    tick(); tick(); tick(); tick();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_full_req got %0h exp 0", bus.mem_req); end
    n_checks++; if (bus.ir_pc !== 32'h200) begin n_fail++; $display("FAIL mid_full_head got %08h exp 200", bus.ir_pc); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req got %0h exp 0", bus.mem_req); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %0h exp 0", bus.ir_valid); end
    n_checks++; if (bus.ir !== 32'h0) begin n_fail++; $display("FAIL mid_rst_ir got %08h exp 0", bus.ir); end
    n_checks++; if (bus.ir_pc4 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pc4 got %08h exp 0", bus.ir_pc4); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_addr got %08h exp 0", bus.mem_addr); end
    n_checks++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL mid_rst_misalign got %0h exp 0", bus.misalign); end
    rst_n = 1'b1;
    bus.ir_ready = 1'b1;
    #1;
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_restart_req got %0h exp 1", bus.mem_req); end
    tick();
    n_checks++; if (bus.ir_pc !== 32'h0) begin n_fail++; $display("FAIL mid_restart_pc got %08h exp 0", bus.ir_pc); end
    n_checks++; if (bus.ir !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mid_restart_ir got %08h exp a5a5a5a5", bus.ir); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.mem_ack_n = 1'b1;
    bus.ir_ready = 1'b0;
    test_reset();
    test_stream();
    test_fill_backpressure();
    test_wait_states();
    test_redirect();
    test_misalign_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
